// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pkg
//  Description : Shared constants and helpers for the parametrised register
//                file: default geometry, address-width calculation and the
//                byte-enable merge used by both storage words and bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

   localparam int REG_WIDTH_DEFAULT = 32;
   localparam int REG_DEPTH_DEFAULT = 32;

   // Widest word the merge helper handles; callers extend to this width and
   // truncate the result back, so unused upper bytes fold away in synthesis.
   localparam int REG_MAX_WIDTH = 1024;

   // Address width for a given depth, never less than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // Byte-wise merge: enabled bytes come from new_word, the rest from old_word.
   function automatic logic [REG_MAX_WIDTH-1:0] byte_merge(
      input logic [REG_MAX_WIDTH-1:0]   old_word,
      input logic [REG_MAX_WIDTH-1:0]   new_word,
      input logic [REG_MAX_WIDTH/8-1:0] be
   );
      logic [REG_MAX_WIDTH-1:0] merged;
      merged = old_word;
      for (int k = 0; k < REG_MAX_WIDTH / 8; k++) begin
         if (be[k]) begin
            merged[8*k +: 8] = new_word[8*k +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_word.sv
`default_nettype none
// ============================================================================
//  Module      : reg_word
//  Description : One WIDTH-bit storage word with byte enables, asynchronous
//                active-high reset and synchronous clear (clear beats write).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_word
   import reg_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH_DEFAULT
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               we,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] be,
   output logic [WIDTH-1:0]   q
);

   logic [WIDTH-1:0] merged;

   assign merged = WIDTH'(byte_merge(REG_MAX_WIDTH'(q),
                                     REG_MAX_WIDTH'(wdata),
                                     (REG_MAX_WIDTH/8)'(be)));

   // Word update: reset and clear zero the word, otherwise enabled bytes load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (we) begin
         q <= merged;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parametrised register file, one byte-enabled write port and
//                two independent read ports. Optional hardwired-zero word 0,
//                write-to-read bypass and registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param
   import reg_pkg::*;
#(
   parameter  int WIDTH    = REG_WIDTH_DEFAULT,
   parameter  int DEPTH    = REG_DEPTH_DEFAULT,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   parameter  int RD_REG   = 0,
   localparam int ADDR_W   = addr_width(DEPTH),
   localparam int NBYTES   = WIDTH / 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [NBYTES-1:0] wr_be,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b
);

   // Depth widened by one bit so the range compare also works when DEPTH is
   // exactly 2**ADDR_W.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  word_q [DEPTH];
   logic              wr_in_range;
   logic              wr_to_zero;
   logic              wr_live;
   logic [ADDR_W-1:0] rd_addr_p [2];
   logic [WIDTH-1:0]  rd_comb   [2];
   logic [WIDTH-1:0]  rd_out    [2];

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
   assign wr_to_zero  = (ZERO_REG != 0) && (wr_addr == '0);

   // A write that will actually land at the next edge; only these bypass.
   assign wr_live = wr_en && !clr && wr_in_range && !wr_to_zero;

   // --------------------------------------------------------------------
   // Storage: one word per address; word 0 is a constant when hardwired.
   // Out-of-range write addresses match no instance, so they are dropped.
   // --------------------------------------------------------------------
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
         assign word_q[i] = '0;
      end else begin : g_store
         logic we;
         assign we = wr_en && (wr_addr == ADDR_W'(i));

         reg_word #(
            .WIDTH (WIDTH)
         ) u_word (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .we    (we),
            .wdata (wr_data),
            .be    (wr_be),
            .q     (word_q[i])
         );
      end
   end

   assign rd_addr_p[0] = rd_addr_a;
   assign rd_addr_p[1] = rd_addr_b;

   // --------------------------------------------------------------------
   // Read ports: range check, optional bypass merge, optional output reg.
   // --------------------------------------------------------------------
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic             in_range;
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] merged;
      logic             hit;

      assign in_range = ({1'b0, rd_addr_p[p]} < DEPTH_EXT);
      assign stored   = in_range ? word_q[rd_addr_p[p]] : '0;
      assign merged   = WIDTH'(byte_merge(REG_MAX_WIDTH'(stored),
                                          REG_MAX_WIDTH'(wr_data),
                                          (REG_MAX_WIDTH/8)'(wr_be)));
      assign hit      = (BYPASS != 0) && wr_live && (wr_addr == rd_addr_p[p]);
      assign rd_comb[p] = hit ? merged : stored;

      if (RD_REG != 0) begin : g_rd_reg
         logic [WIDTH-1:0] rd_q;

         // Capture exactly what the combinational path shows at this edge.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_q <= '0;
            end else begin
               rd_q <= rd_comb[p];
            end
         end

         assign rd_out[p] = rd_q;
      end else begin : g_rd_comb
         assign rd_out[p] = rd_comb[p];
      end
   end

   assign rd_data_a = rd_out[0];
   assign rd_data_b = rd_out[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_param
//  Description : Directed self-checking bench for reg_file_param. Three
//                builds share one stimulus stream:
//                  d0 : default (zero reg, bypass, combinational read)
//                  d1 : no zero reg, no bypass, combinational read
//                  d2 : DEPTH=20, zero reg, bypass, registered read
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] a0, b0, a1, b1, a2, b2;

   int total = 0;
   int bad   = 0;

   reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) d0 (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_addr_a(rd_addr_a), .rd_data_a(a0),
      .rd_addr_b(rd_addr_b), .rd_data_b(b0));

   reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0), .RD_REG(0)) d1 (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_addr_a(rd_addr_a), .rd_data_a(a1),
      .rd_addr_b(rd_addr_b), .rd_data_b(b1));

   reg_file_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1), .BYPASS(1), .RD_REG(1)) d2 (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_addr_a(rd_addr_a), .rd_data_a(a2),
      .rd_addr_b(rd_addr_b), .rd_data_b(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      tick();
      wr_en   = 1'b0;
      wr_be   = 4'h0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      wr_be = '0; rd_addr_a = '0; rd_addr_b = '0;
      #12 rst = 1'b0;
      #1;
      chk("reset_a0", a0, 32'h0);
      chk("reset_b1", b1, 32'h0);
      chk("reset_a2", a2, 32'h0);

      // Asynchronous reset between edges wipes r5 at once
      wr(5'd5, 32'hDEADBEEF, 4'hF);
      rd_addr_a = 5'd5;
      #1;
      chk("pre_rst_a0", a0, 32'hDEADBEEF);
      rst = 1'b1;
      #1;
      chk("rst_async_a0", a0, 32'h0);
      chk("rst_async_a1", a1, 32'h0);
      chk("rst_async_a2", a2, 32'h0);
      #2 rst = 1'b0;
      tick();
      chk("post_rst_a0", a0, 32'h0);
      chk("post_rst_a2", a2, 32'h0);

      // Byte-enabled write
      wr(5'd7, 32'h11223344, 4'hF);
      wr(5'd7, 32'hAABBCCDD, 4'b0101);
      rd_addr_a = 5'd7;
      rd_addr_b = 5'd7;
      #1;
      chk("be_a0", a0, 32'h11BB33DD);
      chk("be_b0", b0, 32'h11BB33DD);
      chk("be_a1", a1, 32'h11BB33DD);
      chk("be_b1", b1, 32'h11BB33DD);
      tick();
      chk("be_a2", a2, 32'h11BB33DD);
      chk("be_b2", b2, 32'h11BB33DD);

      // Bypass vs no bypass on a same-address write
      wr(5'd3, 32'h00000001, 4'hF);
      rd_addr_a = 5'd3;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
      #1;
      chk("byp_a0", a0, 32'hFFFFFFFF);
      chk("nobyp_a1", a1, 32'h00000001);
      tick();
      wr_en = 1'b0; wr_be = 4'h0;
      chk("byp_reg_a2", a2, 32'hFFFFFFFF);
      chk("nobyp_next_a1", a1, 32'hFFFFFFFF);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000000; wr_be = 4'b0011;
      #1;
      chk("byp_part_a0", a0, 32'hFFFF0000);
      chk("nobyp_part_a1", a1, 32'hFFFFFFFF);
      tick();
      wr_be = 4'b0000;
      #1;
      chk("be_zero_byp_a0", a0, 32'hFFFF0000);
      tick();
      wr_en = 1'b0;
      chk("be_zero_keep_a0", a0, 32'hFFFF0000);
      chk("be_zero_keep_a1", a1, 32'hFFFF0000);

      // Zero register
      rd_addr_a = 5'd0;
      rd_addr_b = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; wr_be = 4'hF;
      #1;
      chk("zero_nobyp_a0", a0, 32'h0);
      tick();
      wr_en = 1'b0; wr_be = 4'h0;
      chk("zero_a0", a0, 32'h0);
      chk("zero_b0", b0, 32'h0);
      chk("zero_a1", a1, 32'h12345678);
      chk("zero_b1", b1, 32'h12345678);
      chk("zero_a2", a2, 32'h0);
      chk("zero_b2", b2, 32'h0);

      // Fill r1..r31 with their own index, then clear against a write
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'(i), 4'hF);
      end
      rd_addr_a = 5'd31;
      rd_addr_b = 5'd4;
      #1;
      chk("fill_a0", a0, 32'd31);
      chk("fill_b1", b1, 32'd4);
      tick();
      chk("fill_oor_a2", a2, 32'h0);
      chk("fill_b2", b2, 32'd4);
      clr = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55; wr_be = 4'hF;
      rd_addr_a = 5'd4;
      #1;
      chk("clr_nobyp_a0", a0, 32'd4);
      tick();
      clr = 1'b0; wr_en = 1'b0; wr_be = 4'h0;
      chk("clr_prev_a2", a2, 32'd4);
      for (int i = 0; i < 32; i++) begin
         rd_addr_a = 5'(i);
         rd_addr_b = 5'(i);
         #1;
         chk($sformatf("clr_a0_r%0d", i), a0, 32'h0);
         chk($sformatf("clr_b1_r%0d", i), b1, 32'h0);
      end
      rd_addr_a = 5'd4;
      tick();
      chk("clr_next_a2", a2, 32'h0);

      // Registered read latency and out-of-range handling on DEPTH=20
      wr(5'd19, 32'h000000A5, 4'hF);
      rd_addr_a = 5'd19;
      #1;
      chk("rreg_lat_a2", a2, 32'h0);
      chk("rreg_comb_a0", a0, 32'h000000A5);
      tick();
      chk("rreg_a2", a2, 32'h000000A5);
      rd_addr_a = 5'd25;
      tick();
      chk("rreg_oor_a2", a2, 32'h0);
      wr(5'd25, 32'hFFFFFFFF, 4'hF);
      #1;
      chk("full_depth_r25_a0", a0, 32'hFFFFFFFF);
      chk("oor_read_a2", a2, 32'h0);
      for (int i = 0; i < 20; i++) begin
         rd_addr_b = 5'(i);
         tick();
         chk($sformatf("oor_keep_b2_r%0d", i), b2, (i == 19) ? 32'h000000A5 : 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
